// File: rtl/prefix_add.sv
`default_nettype none
// ============================================================================
// Module   : prefix_add
// Purpose  : WIDTH-bit Kogge-Stone parallel-prefix adder, S = a + b + cin.
//            The prefix network is purely combinational between the ports
//            and a single output register stage. Latency is 1 cycle and
//            throughput is 1 result per cycle.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset (clears S and cout)
//            a, b  - unsigned operands, WIDTH bits
//            cin   - carry into bit 0
//            S     - registered sum, (a+b+cin) mod 2^WIDTH
//            cout  - registered carry-out of the MSB
// Revision : 1.0 - initial release
// ============================================================================
module prefix_add #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] S,
  output logic             cout
);

  localparam int STAGES = $clog2(WIDTH);

  // Per-level group generate/propagate. Level 0 holds the per-bit terms.
  // Level k+1 holds the result after the span-2^k combine.
  logic [STAGES:0][WIDTH-1:0] gs;
  logic [STAGES:0][WIDTH-1:0] ps;
  logic [WIDTH-1:0]           g;
  logic [WIDTH-1:0]           p;
  logic [WIDTH-1:0]           carry;
  logic [WIDTH-1:0]           sum_d;
  logic                       cout_d;
  logic [WIDTH-1:0]           sum_q;
  logic                       cout_q;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gs = '0;
    ps = '0;

    gs[0] = g;
    ps[0] = p;
    // Carry-in is the generate of a virtual bit -1 with P = 0.
    // It is merged into bit 0 up front. Bit 0 then already spans [0 .. -1],
    // so log2(WIDTH) levels reach every group [i .. -1], including the MSB.
    gs[0][0] = g[0] | (p[0] & cin);
    ps[0][0] = 1'b0;

    for (int k = 0; k < STAGES; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        int span;
        int j;
        span = 1 << k;
        // Clamp the partner index so the dead branch never selects out of range.
        j = (i >= span) ? (i - span) : 0;
        if (i >= span) begin
          // Black cell: (G,P) o (G',P') = (G | P&G', P&P')
          gs[k+1][i] = gs[k][i] | (ps[k][i] & gs[k][j]);
          ps[k+1][i] = ps[k][i] & ps[k][j];
        end else begin
          // No lower partner: buffer the already-complete group through.
          gs[k+1][i] = gs[k][i];
          ps[k+1][i] = ps[k][i];
        end
      end
    end

    // Carry into bit i is the group generate over [i-1 .. -1].
    carry  = {gs[STAGES][WIDTH-2:0], cin};
    sum_d  = p ^ carry;
    cout_d = gs[STAGES][WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign S    = sum_q;
  assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_prefix_add.sv
`default_nettype none
// ============================================================================
// Module   : tb_prefix_add
// Purpose  : Self-checking bench for prefix_add (WIDTH = 8). It uses a
//            directed vector table, hand-written reset sequences and a
//            random sweep checked against a behavioural a+b+cin model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prefix_add;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] S;
  logic             cout;

  int total;
  int bad;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_s;
    logic       exp_c;
  } vec_t;

  vec_t vecs [0:13];

  prefix_add #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .S    (S),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {cout,S}=%h expected %h", name, act, exp);
    end
  endtask

  // Drive operands between edges and check the registered result just after the next rising edge.
  task automatic apply(input string name, input logic [7:0] va, input logic [7:0] vb,
                       input logic vc, input logic [7:0] es, input logic ec);
    @(negedge clk);
    a   = va;
    b   = vb;
    cin = vc;
    @(posedge clk);
    #1;
    chk(name, {cout, S}, {ec, es});
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0]  = '{8'd100, 8'd24,  1'b0, 8'd124, 1'b0};
    vecs[1]  = '{8'd20,  8'd178, 1'b0, 8'd198, 1'b0};
    vecs[2]  = '{8'd33,  8'd63,  1'b0, 8'd96,  1'b0};
    vecs[3]  = '{8'd100, 8'd50,  1'b0, 8'd150, 1'b0};
    vecs[4]  = '{8'd100, 8'd40,  1'b0, 8'd140, 1'b0};
    vecs[5]  = '{8'd177, 8'd54,  1'b0, 8'd231, 1'b0};
    vecs[6]  = '{8'd90,  8'd60,  1'b0, 8'd150, 1'b0};
    vecs[7]  = '{8'd24,  8'd76,  1'b0, 8'd100, 1'b0};
    vecs[8]  = '{8'd0,   8'd1,   1'b0, 8'd1,   1'b0};
    vecs[9]  = '{8'hFF,  8'h01,  1'b0, 8'h00,  1'b1};
    vecs[10] = '{8'hFF,  8'h00,  1'b1, 8'h00,  1'b1};
    vecs[11] = '{8'hFF,  8'hFF,  1'b1, 8'hFF,  1'b1};
    vecs[12] = '{8'h00,  8'h00,  1'b1, 8'h01,  1'b0};
    vecs[13] = '{8'h55,  8'hAA,  1'b1, 8'h00,  1'b1};

    // Reset applied with non-zero operands present; outputs must clear without a clock edge.
    rst_n = 1'b1;
    a     = 8'hA5;
    b     = 8'h3C;
    cin   = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {cout, S}, 9'h000);
    @(posedge clk);
    #1;
    chk("reset_hold", {cout, S}, 9'h000);

    @(negedge clk);
    rst_n = 1'b1;
    a     = 8'd0;
    b     = 8'd65;
    cin   = 1'b0;
    @(posedge clk);
    #1;
    chk("first_after_reset", {cout, S}, {1'b0, 8'd65});

    for (int i = 0; i < 14; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
            vecs[i].exp_s, vecs[i].exp_c);
    end

    // Reset mid-stream: drop rst_n between edges while S holds 231.
    apply("pre_reset_231", 8'd177, 8'd54, 1'b0, 8'd231, 1'b0);
    #2;
    rst_n = 1'b0;
    a     = 8'hFF;
    b     = 8'hFF;
    cin   = 1'b1;
    #1;
    chk("midstream_reset", {cout, S}, 9'h000);
    @(posedge clk);
    #1;
    chk("midstream_reset_hold", {cout, S}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    a     = 8'd24;
    b     = 8'd76;
    cin   = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_100", {cout, S}, {1'b0, 8'd100});

    // Random sweep with new operands every cycle.
    for (int n = 0; n < 12000; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      logic [8:0] ref_sum;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      ref_sum = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      apply("sweep", ra, rb, rc, ref_sum[7:0], ref_sum[8]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
